// File: rtl/mc_control_fsm_if.sv
// rtl/mc_control_fsm_if.sv - control bundle between the multicycle sequencer and the datapath
interface mc_control_fsm_if;
    logic [5:0] opcode;
    logic       memReady;
    logic       pcWrite;
    logic       branch;
    logic       bnq;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSrc;
    logic       instrDone;
    logic       illegal;
    logic       halted;
    logic [3:0] state;

    modport master (
        input  opcode, memReady,
        output pcWrite, branch, bnq, iorD, memRead, memWrite, irWrite,
               memtoReg, RegDst, RegWrite, aluSrcA, aluSrcB, aluOp, pcSrc,
               instrDone, illegal, halted, state
    );

    modport slave (
        output opcode, memReady,
        input  pcWrite, branch, bnq, iorD, memRead, memWrite, irWrite,
               memtoReg, RegDst, RegWrite, aluSrcA, aluSrcB, aluOp, pcSrc,
               instrDone, illegal, halted, state
    );
endinterface

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS-subset control sequencer with memory stall timeout
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 15,
    parameter int WAIT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    mc_control_fsm_if.master  bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BEQ      = 4'd8,
        S_BNE      = 4'd9,
        S_ADDIEX   = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_HALT     = 4'd15
    } state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              stall;
    logic              timeout;

    assign stall   = (state_q == S_FETCH || state_q == S_MEMREAD || state_q == S_MEMWRITE)
                     && !bus.memReady;
    assign timeout = stall && (MEM_TIMEOUT != 0) && (wait_q == WAIT_W'(MEM_TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.pcWrite   = 1'b0;
        bus.branch    = 1'b0;
        bus.bnq       = 1'b0;
        bus.iorD      = 1'b0;
        bus.memRead   = 1'b0;
        bus.memWrite  = 1'b0;
        bus.irWrite   = 1'b0;
        bus.memtoReg  = 1'b0;
        bus.RegDst    = 1'b0;
        bus.RegWrite  = 1'b0;
        bus.aluSrcA   = 1'b0;
        bus.aluSrcB   = 2'b00;
        bus.aluOp     = 2'b00;
        bus.pcSrc     = 2'b00;
        bus.instrDone = 1'b0;
        bus.illegal   = 1'b0;
        bus.halted    = 1'b0;
        bus.state     = state_q;

        case (state_q)
            S_FETCH: begin
                bus.memRead = 1'b1;
                bus.aluSrcB = 2'b01;
                bus.irWrite = bus.memReady;
                bus.pcWrite = bus.memReady;
                if (bus.memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                bus.aluSrcB = 2'b11;
                case (bus.opcode)
                    6'b000000:            state_d = S_EXECUTE;
                    6'b100011, 6'b101011: state_d = S_MEMADR;
                    6'b000100:            state_d = S_BEQ;
                    6'b000101:            state_d = S_BNE;
                    6'b001000:            state_d = S_ADDIEX;
                    6'b000010:            state_d = S_JUMP;
                    default: begin
                        bus.illegal = 1'b1;
                        state_d     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_d     = (bus.opcode == 6'b100011) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                bus.iorD    = 1'b1;
                bus.memRead = 1'b1;
                if (bus.memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                bus.memtoReg  = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.iorD      = 1'b1;
                bus.memWrite  = 1'b1;
                bus.instrDone = bus.memReady;
                if (bus.memReady) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                bus.aluSrcA = 1'b1;
                bus.aluOp   = 2'b10;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                bus.RegDst    = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                bus.aluSrcA   = 1'b1;
                bus.aluOp     = 2'b01;
                bus.pcSrc     = 2'b01;
                bus.branch    = (state_q == S_BEQ);
                bus.bnq       = (state_q == S_BNE);
                bus.instrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_ADDIEX: begin
                bus.aluSrcA = 1'b1;
                bus.aluSrcB = 2'b10;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                bus.RegWrite  = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                bus.pcSrc     = 2'b10;
                bus.pcWrite   = 1'b1;
                bus.instrDone = 1'b1;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        if (timeout) state_d = S_HALT;

        // Counter only survives a cycle that stalls and stays put; any progress clears it.
        wait_d = '0;
        if (stall && state_d == state_q)
            wait_d = (wait_q == {WAIT_W{1'b1}}) ? wait_q : wait_q + {{(WAIT_W-1){1'b0}}, 1'b1};

        if (reset) begin
            bus.pcWrite   = 1'b0;
            bus.branch    = 1'b0;
            bus.bnq       = 1'b0;
            bus.iorD      = 1'b0;
            bus.memRead   = 1'b0;
            bus.memWrite  = 1'b0;
            bus.irWrite   = 1'b0;
            bus.memtoReg  = 1'b0;
            bus.RegDst    = 1'b0;
            bus.RegWrite  = 1'b0;
            bus.aluSrcA   = 1'b0;
            bus.aluSrcB   = 2'b00;
            bus.aluOp     = 2'b00;
            bus.pcSrc     = 2'b00;
            bus.instrDone = 1'b0;
            bus.illegal   = 1'b0;
            bus.halted    = 1'b0;
            bus.state     = 4'd0;
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for the multicycle control sequencer
module tb_mc_control_fsm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_control_fsm_if bus();

    mc_control_fsm #(.MEM_TIMEOUT(15), .WAIT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] outs;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    logic [19:0] obs;
    assign obs = {bus.pcWrite, bus.branch, bus.bnq, bus.iorD, bus.memRead, bus.memWrite,
                  bus.irWrite, bus.memtoReg, bus.RegDst, bus.RegWrite, bus.aluSrcA,
                  bus.aluSrcB, bus.aluOp, bus.pcSrc, bus.instrDone, bus.illegal, bus.halted};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Expected control word for a state, written directly from the state table.
    function automatic logic [19:0] model(input logic [3:0] st, input logic mr,
                                          input logic [5:0] op, input logic rst);
        logic pcw, br, bn, iord, mrd, mwr, irw, m2r, rdst, rw, asa, idone, ill, hlt;
        logic [1:0] asb, aop, psrc;
        {pcw, br, bn, iord, mrd, mwr, irw, m2r, rdst, rw, asa, idone, ill, hlt} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        if (!rst) begin
            case (st)
                4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
                4'd1:  begin
                    asb = 2'b11;
                    ill = !(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                       6'b000101, 6'b001000, 6'b000010});
                end
                4'd2:  begin asa = 1; asb = 2'b10; end
                4'd3:  begin iord = 1; mrd = 1; end
                4'd4:  begin m2r = 1; rw = 1; idone = 1; end
                4'd5:  begin iord = 1; mwr = 1; idone = mr; end
                4'd6:  begin asa = 1; aop = 2'b10; end
                4'd7:  begin rdst = 1; rw = 1; idone = 1; end
                4'd8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; idone = 1; end
                4'd9:  begin asa = 1; aop = 2'b01; psrc = 2'b01; bn = 1; idone = 1; end
                4'd10: begin asa = 1; asb = 2'b10; end
                4'd11: begin rw = 1; idone = 1; end
                4'd12: begin psrc = 2'b10; pcw = 1; idone = 1; end
                4'd15: hlt = 1;
                default: ;
            endcase
        end
        return {pcw, br, bn, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, psrc, idone, ill, hlt};
    endfunction

    task automatic step(input logic rst, input logic [5:0] op, input logic mr, input logic [3:0] est);
        exp_t e;
        reset        = rst;
        bus.opcode   = op;
        bus.memReady = mr;
        e.st   = est;
        e.outs = model(est, mr, op, rst);
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        check($sformatf("state@%0d", cyc), {28'd0, bus.state}, {28'd0, e.st});
        check($sformatf("outs@%0d", cyc), {12'd0, obs}, {12'd0, e.outs});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    initial begin
        reset        = 1'b1;
        bus.opcode   = OP_R;
        bus.memReady = 1'b0;
        @(posedge clk);
        #1;

        step(1, OP_R, 1, 4'd0);
        step(1, OP_R, 1, 4'd0);

        step(0, OP_R, 1, 4'd0);
        step(0, OP_R, 1, 4'd1);
        step(0, OP_R, 1, 4'd6);
        step(0, OP_R, 1, 4'd7);

        step(0, OP_LW, 1, 4'd0);
        step(0, OP_LW, 1, 4'd1);
        step(0, OP_LW, 1, 4'd2);
        step(0, OP_LW, 0, 4'd3);
        step(0, OP_LW, 0, 4'd3);
        step(0, OP_LW, 0, 4'd3);
        step(0, OP_LW, 1, 4'd3);
        step(0, OP_LW, 1, 4'd4);

        step(0, OP_SW, 1, 4'd0);
        step(0, OP_SW, 1, 4'd1);
        step(0, OP_SW, 1, 4'd2);
        step(0, OP_SW, 1, 4'd5);

        step(0, OP_BNE, 1, 4'd0);
        step(0, OP_BNE, 1, 4'd1);
        step(0, OP_BNE, 1, 4'd9);
        step(0, OP_J,   1, 4'd0);
        step(0, OP_J,   1, 4'd1);
        step(0, OP_J,   1, 4'd12);

        step(0, OP_BAD, 1, 4'd0);
        step(0, OP_BAD, 1, 4'd1);

        step(0, OP_LW, 1, 4'd0);
        step(0, OP_LW, 1, 4'd1);
        step(0, OP_LW, 1, 4'd2);
        step(0, OP_LW, 0, 4'd3);
        step(0, OP_LW, 0, 4'd3);
        step(1, OP_LW, 0, 4'd0);

        // Exactly MEM_TIMEOUT stall cycles must still complete.
        for (int i = 0; i < 15; i++) step(0, OP_R, 0, 4'd0);
        step(0, OP_R, 1, 4'd0);
        step(0, OP_R, 1, 4'd1);
        step(0, OP_R, 1, 4'd6);
        step(0, OP_R, 1, 4'd7);

        for (int i = 0; i < 16; i++) step(0, OP_R, 0, 4'd0);
        for (int i = 0; i < 3; i++)  step(0, OP_R, 1, 4'd15);

        step(1, OP_R, 1, 4'd0);
        step(0, OP_R, 1, 4'd0);
        step(0, OP_R, 1, 4'd1);

        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle sequencer for the MIPS-subset datapath: R-type, lw, sw, beq, bne, j, addi.
- Replaces the single-cycle combinational control. It drives the shared-ALU/shared-memory datapath one step per clock: IR, A/B, ALUOut and MDR registers, plus one unified memory port.
- The memory port may stall. The FSM holds on memReady and halts after a bounded wait.
- The datapath forms the PC enable as pcWrite | (branch & zero) | (bnq & ~zero).

Parameters:
MEM_TIMEOUT, 15, max consecutive memReady=0 cycles tolerated in one memory state; 0 disables the timeout
WAIT_W, 4, width of the wait counter; must hold MEM_TIMEOUT

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
opcode  in  6  instruction[31:26] from IR
memReady  in  1  memory completes the current read/write this cycle
pcWrite  out  1  unconditional PC load
branch  out  1  beq conditional PC load
bnq  out  1  bne conditional PC load
iorD  out  1  memory address: 0=PC, 1=ALUOut
memRead  out  1  memory read request
memWrite  out  1  memory write request
irWrite  out  1  IR load
memtoReg  out  1  write-back select: 1=MDR, 0=ALUOut
RegDst  out  1  write register: 1=rd, 0=rt
RegWrite  out  1  register-file write enable
aluSrcA  out  1  ALU A: 0=PC, 1=A reg
aluSrcB  out  2  ALU B: 00=B reg, 01=4, 10=sign_imm, 11=sign_imm<<2
aluOp  out  2  00=add, 01=sub, 10=funct-decoded (feeds the existing ALU control decoder)
pcSrc  out  2  00=ALU result, 01=ALUOut, 10=jump address
instrDone  out  1  one-cycle pulse on the last cycle of each instruction
illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
halted  out  1  FSM is in HALT
state  out  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BEQ=8, BNE=9, ADDIEX=10, ADDIWB=11, JUMP=12, HALT=15.
- Outputs are Moore-decoded from the state, except the memReady-gated signals noted below. Any output not listed for a state is 0.
- Reset:
  - Reset high at a clock edge: state<=FETCH, wait counter<=0.
  - While reset is high, every output is forced to 0, including state=0 and halted=0.
  - Reset overrides all states, including HALT and mid-stall states.
- FETCH: iorD=0, memRead=1, aluSrcA=0, aluSrcB=01, aluOp=00, pcSrc=00.
  - irWrite=pcWrite=memReady.
  - Advance to DECODE only when memReady=1; otherwise hold.
- DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target into ALUOut).
  - Next state by opcode: 000000->EXECUTE; 100011 or 101011->MEMADR; 000100->BEQ; 000101->BNE; 001000->ADDIEX; 000010->JUMP.
  - Any other opcode: illegal=1, next state FETCH.
- MEMADR: aluSrcA=1, aluSrcB=10, aluOp=00. Next MEMREAD if opcode=100011, else MEMWRITE.
- MEMREAD: iorD=1, memRead=1. Hold until memReady, then MEMWB.
- MEMWB: RegDst=0, memtoReg=1, RegWrite=1, instrDone=1. Next FETCH.
- MEMWRITE: iorD=1, memWrite=1, instrDone=memReady. Hold until memReady, then FETCH.
- EXECUTE: aluSrcA=1, aluSrcB=00, aluOp=10. Next ALUWB.
- ALUWB: RegDst=1, memtoReg=0, RegWrite=1, instrDone=1. Next FETCH.
- BEQ: aluSrcA=1, aluSrcB=00, aluOp=01, pcSrc=01, branch=1, instrDone=1. Next FETCH.
- BNE: same as BEQ, with bnq=1 instead of branch. Next FETCH.
- ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00. Next ADDIWB.
- ADDIWB: RegDst=0, memtoReg=0, RegWrite=1, instrDone=1. Next FETCH.
- JUMP: pcSrc=10, pcWrite=1, instrDone=1. Next FETCH.
- Latency with zero-wait memory: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi 4 cycles. Each wait cycle adds 1.
- Wait counter:
  - In FETCH, MEMREAD or MEMWRITE with memReady=0, it increments, saturating at its maximum.
  - It clears on memReady=1 and on any state change.
  - With MEM_TIMEOUT>0: if memReady=0 and the counter equals MEM_TIMEOUT, the next state is HALT.
  - A stall of exactly MEM_TIMEOUT cycles followed by memReady=1 completes normally. The (MEM_TIMEOUT+1)th zero halts.
- HALT: all outputs 0 except halted=1 and state=15. Only reset exits HALT.
- memWrite and memRead are never asserted in the same cycle.
- RegWrite is asserted only in MEMWB, ALUWB and ADDIWB.
- Unused encodings 13 and 14 go to HALT.

Test Plan:
- Reset for 2 cycles, then opcode=000000 with memReady=1 constantly -> states 0,1,6,7,0. instrDone high only in state 7. RegWrite=1 and RegDst=1 in state 7.
- opcode=100011 with memReady low for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0. memRead=1 and iorD=1 in every state-3 cycle. memtoReg=1 in state 4.
- opcode=101011 with memReady=1 -> states 0,1,2,5,0. memWrite=1 and instrDone=1 in state 5. RegWrite never 1.
- opcode=000101 -> states 0,1,9. bnq=1, pcSrc=01, aluOp=01 in state 9. Then opcode=000010 -> pcWrite=1, pcSrc=10 in state 12.
- opcode=111111 -> illegal pulses exactly in the DECODE cycle and the next state is 0. Reset asserted mid-MEMREAD stall -> all outputs 0 during reset, then state 0.
- MEM_TIMEOUT=15, memReady=0 held in FETCH -> 15 wait cycles, then 16th zero -> HALT, halted=1. The FSM stays in HALT with memReady=1 until reset.
